// File: rtl/sram_controller.sv
// sram_controller: turns one 32-bit load/store from the memory stage into two
// 16-bit accesses to an asynchronous SRAM. Each half-word phase lasts
// SRAM_WAIT cycles. ready is held low for the whole access so the pipeline
// freezes until the access completes.
module sram_controller #(
  parameter int BASE_ADDR = 1024,
  parameter int SRAM_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [31:0] BASE = 32'(BASE_ADDR);
  localparam logic [3:0]  LAST = 4'(SRAM_WAIT - 1);

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic        is_store;
  logic [16:0] widx;
  logic        half;
  logic        addr_en;
  logic        dq_oe;
  logic [15:0] dq_out;
  logic        cap_lo, cap_hi;

  // Word index relative to the SRAM window; upper bits drop so accesses wrap
  // modulo 128K words.
  assign widx = 17'((address - BASE) >> 2);

  assign SRAM_ADDR = addr_en ? {widx, half} : 18'd0;
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // State, phase counter, latched op type and the load-result register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      is_store  <= 1'b0;
      read_data <= 32'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (state == IDLE && (rd_en || wr_en))
        is_store <= wr_en;  // a store wins when both requests are high
      if (cap_lo)
        read_data[15:0] <= SRAM_DQ;
      if (cap_hi)
        read_data[31:16] <= SRAM_DQ;
    end
  end

  // Next-state, counter and all SRAM-side / pipeline-side controls.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    next_state = state;
    next_cnt   = cnt;
    ready      = 1'b0;
    SRAM_WE_N  = 1'b1;
    dq_oe      = 1'b0;
    dq_out     = write_data[15:0];
    half       = 1'b0;
    addr_en    = 1'b0;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;

    unique case (state)
      IDLE: begin
        ready = ~(rd_en | wr_en);
        if (rd_en || wr_en) begin
          next_state = LOW;
          next_cnt   = 4'd0;
        end
      end
      LOW: begin
        addr_en  = 1'b1;
        next_cnt = cnt + 4'd1;
        if (cnt == LAST) begin
          next_state = HIGH;
          next_cnt   = 4'd0;
        end
        if (is_store) begin
          dq_oe     = 1'b1;
          // Strobe released on the last cycle so addr/data are stable across
          // its rising edge.
          SRAM_WE_N = (cnt == LAST);
        end else begin
          cap_lo = (cnt == LAST);
        end
      end
      HIGH: begin
        addr_en  = 1'b1;
        half     = 1'b1;
        dq_out   = write_data[31:16];
        next_cnt = cnt + 4'd1;
        if (cnt == LAST) begin
          next_state = DONE;
          next_cnt   = 4'd0;
        end
        if (is_store) begin
          dq_oe     = 1'b1;
          SRAM_WE_N = (cnt == LAST);
        end else begin
          cap_hi = (cnt == LAST);
        end
      end
      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle memory-access engine between the memory stage and the board's 16-bit asynchronous SRAM. It accepts one 32-bit load or store per request from the memory stage and performs it as two 16-bit SRAM half-word accesses with a fixed wait count. It drives `ready` low for the whole access so the pipeline freezes, then returns load data, registered and held.

## Interface
Parameters:
- `BASE_ADDR`, 1024: CPU byte address that maps to SRAM word 0.
- `SRAM_WAIT`, 2: cycles per half-word phase; legal range 2–15.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-low (`rst==0` resets on the next rising `clk`).
- `rd_en`  in  1  load request; held by the memory stage until `ready`.
- `wr_en`  in  1  store request; held until `ready`.
- `address`  in  32  CPU byte address (ALU result).
- `write_data`  in  32  store data (Rm value).
- `read_data`  out  32  registered load result.
- `ready`  out  1  high = no access in progress / access complete this cycle.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_WE_N`  out  1  SRAM write strobe, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each  tied to 0.

## Operation
- Address: `widx = (address - BASE_ADDR) >> 2` (32-bit subtract, wraps); `SRAM_ADDR = {widx[16:0], half}`, where `half` is 0 in LOW and 1 in HIGH. Bits `address[1:0]` and `widx[29:17]` are ignored, so accesses wrap modulo 128K words.
- Priority: if both `rd_en` and `wr_en` are high, the access is a store.
- FSM states are IDLE, LOW, HIGH, DONE. Counter `cnt` is 4 bits.
- IDLE: if `wr_en|rd_en`, latch the op type, go to LOW, and set `cnt=0`. Otherwise stay in IDLE.
- LOW: `cnt` increments each cycle. When `cnt==SRAM_WAIT-1`, go to HIGH and clear `cnt`.
- HIGH: same counting as LOW; at `cnt==SRAM_WAIT-1`, go to DONE.
- DONE: unconditionally go to IDLE.
- Store in LOW/HIGH:
  - `SRAM_DQ` is driven with `write_data[15:0]` in LOW and `write_data[31:16]` in HIGH.
  - `SRAM_WE_N=0` when `cnt<SRAM_WAIT-1`, and 1 on the last cycle of each phase, so address and data stay stable across the strobe's rising edge.
- Load:
  - `SRAM_DQ` is high-Z and `SRAM_WE_N=1`.
  - On the last cycle of LOW, capture `SRAM_DQ` into `read_data[15:0]`; on the last cycle of HIGH, capture it into `read_data[31:16]`.
  - `read_data` changes only on loads and otherwise holds its value. Stores never modify it.
- `SRAM_DQ` is high-Z in IDLE and DONE, and during loads.
- `ready`: in IDLE it is `~(rd_en|wr_en)` (combinational). It is 0 in LOW and HIGH, and 1 in DONE.
- Requests must stay stable until `ready`. Changes mid-access are ignored; the latched op type and the current `address`/`write_data` are used.

## Timing
- Reset values: state IDLE, `cnt=0`, `read_data=0`, `SRAM_WE_N=1`, `SRAM_DQ` high-Z, `SRAM_ADDR=0`.
- `ready` after reset follows the IDLE rule.
- Latency: a request first seen in IDLE at cycle 0 gives `ready=1` at cycle `2*SRAM_WAIT+1`. With `SRAM_WAIT=2` that is cycle 5, and `ready` is low during cycles 0–4.
- Load data is valid in `read_data` from the DONE cycle onward.
- Back-to-back: DONE→IDLE costs one cycle. A request present in that IDLE cycle starts immediately, giving a period of `2*SRAM_WAIT+2`.
- The request from the completed instruction is still asserted during DONE. It is not restarted, because DONE always goes to IDLE and the pipeline advances on that same edge.
- Reset mid-access: the next edge forces IDLE, `SRAM_WE_N=1`, releases the bus and clears `read_data`. Any partial store is abandoned.

## Test plan
- Reset with no request: hold `rst=0` for 2 cycles, then release with `rd_en=wr_en=0` → `ready=1`, `read_data=0`, `SRAM_WE_N=1`, bus high-Z.
- Store then load: store `address=1024`, `write_data=32'hDEADBEEF` → SRAM[0]=`BEEF`, SRAM[1]=`DEAD`, `ready` low for 5 cycles. Then load 1024 → `read_data=32'hDEADBEEF` at cycle 5.
- Address map and wrap: store `address=1024+4*131072+8`, data `32'h12345678` → `SRAM_ADDR` = 4 then 5. A load from 1032 returns `32'h12345678`.
- Simultaneous `rd_en=wr_en=1` with `write_data=32'hA5A5_0F0F` → store performed, `read_data` unchanged.
- Back-to-back: two loads, with the second request presented in the cycle after DONE → second `ready` exactly 6 cycles after the first.
- Reset mid-store: assert `rst=0` during cycle 1 of HIGH → next cycle IDLE, `SRAM_WE_N=1`, `SRAM_DQ` high-Z, `read_data=0`.
